// File: rtl/dkjr_input_cond.sv
// -----------------------------------------------------------------------------
// dkjr_input_cond
//
// Conditions the HPS joystick words into the active-low control inputs that
// dkongjr_top expects:
//   - every raw button goes through a 2-flop synchroniser;
//   - opposing directions on each axis are resolved "last pressed wins";
//   - coin presses are queued (up to MAX_PEND) and replayed as fixed-width
//     pulses separated by a minimum released gap;
//   - coin timing (and autofire) freeze while the CPU is paused, so a credit
//     is never lost or shortened.
//
// Optional feature macro: DKJR_AUTOFIRE_EN
//   defined   : jump autofires at AF_HALF cycles per phase while I_AUTOFIRE=1
//   undefined : jump is a plain pass-through, I_AUTOFIRE is ignored
//
// Ports
//   I_CLK_24576M  in   1  system clock
//   I_RESETn      in   1  synchronous active-low reset
//   I_JOY1        in   5  P1 {jump,up,down,left,right}, active-high
//   I_JOY2        in   5  P2 {jump,up,down,left,right}, active-high
//   I_COIN        in   1  coin button, active-high
//   I_START1      in   1  start 1, active-high
//   I_START2      in   1  start 2, active-high
//   I_PAUSE       in   1  CPU pause; freezes coin FSM and autofire
//   I_AUTOFIRE    in   1  autofire enable
//   O_P1n         out  5  P1 {J,U,D,L,R}, active-low
//   O_P2n         out  5  P2 {J,U,D,L,R}, active-low
//   O_C1n         out  1  coin pulse, active-low
//   O_S1n         out  1  start 1, active-low
//   O_S2n         out  1  start 2, active-low
//   O_COIN_PEND   out  2  queued coins not yet issued
//   O_COIN_STATE  out  2  coin FSM state (0 idle, 1 pulse, 2 gap), debug
//
// No valid/ready handshakes exist in this block; all inputs are level signals.
// -----------------------------------------------------------------------------
module dkjr_input_cond #(
   parameter int         COIN_PULSE = 2457600,
   parameter int         COIN_GAP   = 2457600,
   parameter logic [1:0] MAX_PEND   = 2'd3,
   parameter int         AF_HALF    = 204800
) (
   input  logic       I_CLK_24576M,
   input  logic       I_RESETn,
   input  logic [4:0] I_JOY1,
   input  logic [4:0] I_JOY2,
   input  logic       I_COIN,
   input  logic       I_START1,
   input  logic       I_START2,
   input  logic       I_PAUSE,
   input  logic       I_AUTOFIRE,
   output logic [4:0] O_P1n,
   output logic [4:0] O_P2n,
   output logic       O_C1n,
   output logic       O_S1n,
   output logic       O_S2n,
   output logic [1:0] O_COIN_PEND,
   output logic [1:0] O_COIN_STATE
);

   // ---------------------------------------------------------------------------
   // Coin counter width: large enough for the longer of pulse and gap.
   // ---------------------------------------------------------------------------
   localparam int CMAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   // Axis memory: A is left (H) / up (V), B is right (H) / down (V).
   typedef enum logic [1:0] {
      AX_NEUTRAL = 2'd0,
      AX_A       = 2'd1,
      AX_B       = 2'd2
   } axis_t;

   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_PULSE = 2'd1,
      C_GAP   = 2'd2
   } coin_st_t;

   // Raw input bundle: [12] start2, [11] start1, [10] coin, [9:5] joy2, [4:0] joy1
   logic [12:0] raw;
   logic [12:0] sync1;
   logic [12:0] sync2;

   // Previous synced values, only for bits that need edge detection
   logic [3:0]  dir1_d;
   logic [3:0]  dir2_d;
   logic        coin_d;

   logic [3:0]  rise1;
   logic [3:0]  rise2;
   logic        coin_rise;

   axis_t       last_h1, last_v1, last_h2, last_v2;
   axis_t       h1_nxt, v1_nxt, h2_nxt, v2_nxt;

   logic        jump1_act;
   logic        jump2_act;
   logic [4:0]  p1_act;
   logic [4:0]  p2_act;

   logic [4:0]  p1n_q;
   logic [4:0]  p2n_q;
   logic        s1n_q;
   logic        s2n_q;

   coin_st_t    coin_st, coin_nxt;
   logic [CW-1:0] coin_cnt, cnt_nxt;
   logic [1:0]  pend, pend_nxt;
   logic        deq;

   assign raw = {I_START2, I_START1, I_COIN, I_JOY2, I_JOY1};

   // ---------------------------------------------------------------------------
   // SOCD helpers
   // ---------------------------------------------------------------------------
   // New axis memory given rising edges on side A and side B this cycle.
   function automatic axis_t axis_next(input axis_t last, input logic ra,
                                       input logic rb);
      axis_t r;
      if (ra && rb) begin
         r = AX_NEUTRAL;
      end else if (ra) begin
         r = AX_A;
      end else if (rb) begin
         r = AX_B;
      end else begin
         r = last;
      end
      return r;
   endfunction

   // Resolved {a,b} active-high. The up-to-date memory is used so a press
   // that creates the conflict takes effect with the same latency as any
   // other button.
   function automatic logic [1:0] axis_out(input logic a, input logic b,
                                           input axis_t last);
      logic [1:0] r;
      if (a && b) begin
         case (last)
            AX_A:    r = 2'b10;
            AX_B:    r = 2'b01;
            default: r = 2'b00;
         endcase
      end else begin
         r = {a, b};
      end
      return r;
   endfunction

   always_comb begin
      rise1     = sync2[3:0] & ~dir1_d;
      rise2     = sync2[8:5] & ~dir2_d;
      coin_rise = sync2[10] & ~coin_d;

      h1_nxt = axis_next(last_h1, rise1[1], rise1[0]);
      v1_nxt = axis_next(last_v1, rise1[3], rise1[2]);
      h2_nxt = axis_next(last_h2, rise2[1], rise2[0]);
      v2_nxt = axis_next(last_v2, rise2[3], rise2[2]);

      p1_act = {jump1_act,
                axis_out(sync2[3], sync2[2], v1_nxt),
                axis_out(sync2[1], sync2[0], h1_nxt)};
      p2_act = {jump2_act,
                axis_out(sync2[8], sync2[7], v2_nxt),
                axis_out(sync2[6], sync2[5], h2_nxt)};
   end

   // ---------------------------------------------------------------------------
   // Jump / autofire
   // ---------------------------------------------------------------------------
`ifdef DKJR_AUTOFIRE_EN
   localparam int AW = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;

   logic [AW-1:0] af_cnt;
   logic          af_ph1;
   logic          af_ph2;
   logic          af_hold1;
   logic          af_hold2;
   logic          af_tick;

   assign af_hold1 = I_AUTOFIRE & sync2[4];
   assign af_hold2 = I_AUTOFIRE & sync2[9];
   assign af_tick  = (af_hold1 | af_hold2) && (af_cnt == AW'(AF_HALF - 1));

   // Phase 0 means "pressed"; a fresh press therefore asserts immediately.
   assign jump1_act = sync2[4] & ~(I_AUTOFIRE & af_ph1);
   assign jump2_act = sync2[9] & ~(I_AUTOFIRE & af_ph2);

   // The counter is shared by both players and restarts only when nobody is
   // holding an autofiring jump.
   always_ff @(posedge I_CLK_24576M) begin
      if (!I_RESETn) begin
         af_cnt <= '0;
         af_ph1 <= 1'b0;
         af_ph2 <= 1'b0;
      end else if (!I_PAUSE) begin
         if (!(af_hold1 | af_hold2) || af_tick) begin
            af_cnt <= '0;
         end else begin
            af_cnt <= af_cnt + AW'(1);
         end
         af_ph1 <= af_hold1 ? (af_ph1 ^ af_tick) : 1'b0;
         af_ph2 <= af_hold2 ? (af_ph2 ^ af_tick) : 1'b0;
      end
   end
`else
   logic unused_autofire;
   localparam int unused_af_half = AF_HALF;

   assign unused_autofire = I_AUTOFIRE;
   assign jump1_act       = sync2[4];
   assign jump2_act       = sync2[9];
`endif

   // ---------------------------------------------------------------------------
   // Coin FSM and queue
   // ---------------------------------------------------------------------------
   always_comb begin
      coin_nxt = coin_st;
      cnt_nxt  = coin_cnt;
      deq      = 1'b0;
      if (!I_PAUSE) begin
         case (coin_st)
            C_IDLE: begin
               if (pend != 2'd0) begin
                  cnt_nxt  = CW'(COIN_PULSE - 1);
                  deq      = 1'b1;
                  coin_nxt = C_PULSE;
               end
            end
            C_PULSE: begin
               if (coin_cnt == '0) begin
                  cnt_nxt  = CW'(COIN_GAP - 1);
                  coin_nxt = C_GAP;
               end else begin
                  cnt_nxt = coin_cnt - CW'(1);
               end
            end
            C_GAP: begin
               if (coin_cnt == '0) begin
                  coin_nxt = C_IDLE;
               end else begin
                  cnt_nxt = coin_cnt - CW'(1);
               end
            end
            default: begin
               coin_nxt = C_IDLE;
            end
         endcase
      end

      // A press and a dequeue in the same cycle cancel, even when full.
      pend_nxt = pend;
      if (coin_rise && deq) begin
         pend_nxt = pend;
      end else if (coin_rise) begin
         pend_nxt = (pend == MAX_PEND) ? pend : pend + 2'd1;
      end else if (deq) begin
         pend_nxt = pend - 2'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge I_CLK_24576M) begin
      if (!I_RESETn) begin
         sync1    <= '0;
         sync2    <= '0;
         dir1_d   <= '0;
         dir2_d   <= '0;
         coin_d   <= 1'b0;
         last_h1  <= AX_NEUTRAL;
         last_v1  <= AX_NEUTRAL;
         last_h2  <= AX_NEUTRAL;
         last_v2  <= AX_NEUTRAL;
         p1n_q    <= '1;
         p2n_q    <= '1;
         s1n_q    <= 1'b1;
         s2n_q    <= 1'b1;
         coin_st  <= C_IDLE;
         coin_cnt <= '0;
         pend     <= '0;
      end else begin
         sync1    <= raw;
         sync2    <= sync1;
         dir1_d   <= sync2[3:0];
         dir2_d   <= sync2[8:5];
         coin_d   <= sync2[10];
         last_h1  <= h1_nxt;
         last_v1  <= v1_nxt;
         last_h2  <= h2_nxt;
         last_v2  <= v2_nxt;
         p1n_q    <= ~p1_act;
         p2n_q    <= ~p2_act;
         s1n_q    <= ~sync2[11];
         s2n_q    <= ~sync2[12];
         coin_st  <= coin_nxt;
         coin_cnt <= cnt_nxt;
         pend     <= pend_nxt;
      end
   end

   assign O_P1n        = p1n_q;
   assign O_P2n        = p2n_q;
   assign O_S1n        = s1n_q;
   assign O_S2n        = s2n_q;
   // Decoded straight from the state register: glitch-free, and a reset
   // releases the coin line on the very next cycle.
   assign O_C1n        = (coin_st != C_PULSE);
   assign O_COIN_PEND  = pend;
   assign O_COIN_STATE = coin_st;

endmodule

// File: tb/tb_dkjr_input_cond.sv
// -----------------------------------------------------------------------------
// tb_dkjr_input_cond
//
// Directed bench for dkjr_input_cond with short coin/autofire timings
// (COIN_PULSE=4, COIN_GAP=3, AF_HALF=2). Inputs are driven and outputs
// sampled 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_dkjr_input_cond;

   localparam int COIN_PULSE = 4;
   localparam int COIN_GAP   = 3;
   localparam int AF_HALF    = 2;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] joy1;
   logic [4:0] joy2;
   logic       coin;
   logic       start1;
   logic       start2;
   logic       pause;
   logic       autofire;

   logic [4:0] p1n;
   logic [4:0] p2n;
   logic       c1n;
   logic       s1n;
   logic       s2n;
   logic [1:0] coin_pend;
   logic [1:0] coin_state;

   always #5 clk = ~clk;

   dkjr_input_cond #(
      .COIN_PULSE (COIN_PULSE),
      .COIN_GAP   (COIN_GAP),
      .MAX_PEND   (2'd3),
      .AF_HALF    (AF_HALF)
   ) dut (
      .I_CLK_24576M (clk),
      .I_RESETn     (rst_n),
      .I_JOY1       (joy1),
      .I_JOY2       (joy2),
      .I_COIN       (coin),
      .I_START1     (start1),
      .I_START2     (start2),
      .I_PAUSE      (pause),
      .I_AUTOFIRE   (autofire),
      .O_P1n        (p1n),
      .O_P2n        (p2n),
      .O_C1n        (c1n),
      .O_S1n        (s1n),
      .O_S2n        (s2n),
      .O_COIN_PEND  (coin_pend),
      .O_COIN_STATE (coin_state)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Scoreboard and checking
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Coin line monitor: records widths of low runs and of high runs that
   // separate two pulses, plus the peak queue depth.
   bit mon_en = 1'b0;
   int low_run;
   int high_run;
   bit seen_pulse;
   int pend_max;
   int lows[$];
   int gaps[$];

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (int'(coin_pend) > pend_max) pend_max = int'(coin_pend);
         if (c1n == 1'b0) begin
            if (seen_pulse && high_run > 0) gaps.push_back(high_run);
            high_run = 0;
            low_run++;
         end else begin
            if (low_run > 0) begin
               lows.push_back(low_run);
               seen_pulse = 1'b1;
            end
            low_run = 0;
            high_run++;
         end
      end
   end

   task automatic mon_start();
      mon_en = 1'b0;
      lows.delete();
      gaps.delete();
      low_run    = 0;
      high_run   = 0;
      seen_pulse = 1'b0;
      pend_max   = 0;
      mon_en     = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_all(input logic v);
      joy1     = {5{v}};
      joy2     = {5{v}};
      coin     = v;
      start1   = v;
      start2   = v;
      pause    = v;
      autofire = v;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   logic [5:0] af_exp;

   initial begin
      rst_n = 1'b0;
      set_all(1'b1);

      // 1. Reset with all inputs high
      step(4);
      check("rst_p1n", 32'(p1n), 32'h1f);
      check("rst_p2n", 32'(p2n), 32'h1f);
      check("rst_c1n", 32'(c1n), 32'h1);
      check("rst_s1n", 32'(s1n), 32'h1);
      check("rst_s2n", 32'(s2n), 32'h1);
      check("rst_pend", 32'(coin_pend), 32'h0);
      check("rst_state", 32'(coin_state), 32'h0);
      set_all(1'b0);
      step(3);
      rst_n = 1'b1;
      step(3);
      check("idle_p1n", 32'(p1n), 32'h1f);

      joy1 = 5'b00001;
      step(2);
      check("lat_p1n_2cyc", 32'(p1n), 32'h1f);
      step(1);
      check("lat_p1n_3cyc", 32'(p1n), 32'h1e);
      joy1 = 5'b00000;
      start1 = 1'b1;
      step(3);
      check("start1_on", 32'(s1n), 32'h0);
      check("right_release", 32'(p1n), 32'h1f);
      start1 = 1'b0;
      start2 = 1'b1;
      step(3);
      check("start2_on", 32'(s2n), 32'h0);
      check("start1_off", 32'(s1n), 32'h1);
      start2 = 1'b0;
      step(3);

      // 2. SOCD
      joy1 = 5'b00010;
      step(5);
      check("socd_left", 32'(p1n[1:0]), 32'h1);
      joy1 = 5'b00011;
      step(3);
      check("socd_r_wins", 32'(p1n[1:0]), 32'h2);
      joy1 = 5'b00010;
      step(3);
      check("socd_back_l", 32'(p1n[1:0]), 32'h1);
      joy1 = 5'b00000;
      step(3);
      joy1 = 5'b00011;
      step(3);
      check("socd_both_neutral", 32'(p1n[1:0]), 32'h3);
      step(2);
      check("socd_both_hold", 32'(p1n[1:0]), 32'h3);
      joy1 = 5'b00000;
      joy2 = 5'b01000;
      step(4);
      check("socd_v_up", 32'(p2n[3:2]), 32'h1);
      joy2 = 5'b01100;
      step(3);
      check("socd_v_down_wins", 32'(p2n[3:2]), 32'h2);
      joy2 = 5'b00000;
      step(3);
      check("socd_release", 32'(p2n), 32'h1f);

      // 3. Single coin
      coin = 1'b1;
      step(1);
      coin = 1'b0;
      step(2);
      check("coin_pend_1", 32'(coin_pend), 32'h1);
      check("coin_not_yet", 32'(c1n), 32'h1);
      mon_start();
      step(1);
      check("coin_lat4", 32'(c1n), 32'h0);
      check("coin_pend_0", 32'(coin_pend), 32'h0);
      step(15);
      mon_en = 1'b0;
      check("coin1_count", 32'(lows.size()), 32'd1);
      check("coin1_width", 32'(lows.size() > 0 ? lows[0] : 0), 32'(COIN_PULSE));
      check("coin1_gap_min", 32'(high_run >= COIN_GAP), 32'h1);

      // 4. Five presses two cycles apart: one immediate, three queued, one dropped
      mon_start();
      for (int i = 0; i < 5; i++) begin
         coin = 1'b1;
         step(1);
         coin = 1'b0;
         step(1);
      end
      step(40);
      mon_en = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(COIN_PULSE));
      check("burst_pend_peak", 32'(pend_max), 32'd3);
      check("burst_count", 32'(lows.size()), 32'd4);
      for (int i = 0; i < lows.size(); i++) begin
         if (exp_q.size() > 0) check("burst_width", 32'(lows[i]), exp_q.pop_front());
      end
      exp_q.delete();
      check("burst_gap_count", 32'(gaps.size()), 32'd3);
      for (int i = 0; i < gaps.size(); i++) begin
         // at least COIN_GAP released, plus at most the IDLE dequeue cycle
         check("burst_gap", 32'(gaps[i] >= COIN_GAP && gaps[i] <= COIN_GAP + 1), 32'h1);
      end
      check("burst_pend_end", 32'(coin_pend), 32'h0);

      // 5. Pause in the second cycle of a pulse, with a press while paused
      mon_start();
      coin = 1'b1;
      step(1);
      coin = 1'b0;
      step(3);
      check("pause_pulse_start", 32'(c1n), 32'h0);
      step(1);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i == 1) coin = 1'b1;
         if (i == 2) coin = 1'b0;
         step(1);
      end
      check("pause_state", 32'(coin_state), 32'h1);
      check("pause_c1n", 32'(c1n), 32'h0);
      check("pause_enqueue", 32'(coin_pend), 32'h1);
      pause = 1'b0;
      step(25);
      mon_en = 1'b0;
      check("pause_pulses", 32'(lows.size()), 32'd2);
      check("pause_low_total", 32'(lows.size() > 0 ? lows[0] : 0), 32'd14);
      check("pause_second", 32'(lows.size() > 1 ? lows[1] : 0), 32'(COIN_PULSE));

      // Reset in the middle of a pulse with coins queued
      for (int i = 0; i < 3; i++) begin
         coin = 1'b1;
         step(1);
         coin = 1'b0;
         step(1);
      end
      step(1);
      check("pre_reset_pend", 32'(coin_pend), 32'd2);
      check("pre_reset_pulse", 32'(c1n), 32'h0);
      rst_n = 1'b0;
      step(1);
      check("reset_abort_c1n", 32'(c1n), 32'h1);
      check("reset_abort_pend", 32'(coin_pend), 32'h0);
      check("reset_abort_state", 32'(coin_state), 32'h0);
      rst_n = 1'b1;
      step(10);
      check("post_reset_c1n", 32'(c1n), 32'h1);
      check("post_reset_pend", 32'(coin_pend), 32'h0);

      // 6. Jump with autofire requested
`ifdef DKJR_AUTOFIRE_EN
      af_exp = 6'b001100;
`else
      af_exp = 6'b000000;
`endif
      autofire = 1'b1;
      joy2 = 5'b10000;
      step(3);
      for (int i = 0; i < 6; i++) begin
         check("af_jump", 32'(p2n[4]), 32'(af_exp[i]));
         step(1);
      end
      joy2 = 5'b00000;
      step(3);
      check("af_release", 32'(p2n[4]), 32'h1);
      check("af_p1_idle", 32'(p1n), 32'h1f);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
